// File: rtl/regfile_wb_queue_pkg.sv
// Shared types and default sizing for the regfile writeback staging queue.
package wbq_pkg;

    localparam int unsigned WBQ_WIDTH    = 32;
    localparam int unsigned WBQ_AW       = 6;
    localparam int unsigned WBQ_DEPTH    = 8;
    localparam int unsigned WBQ_RD_PORTS = 6;
    localparam int unsigned WBQ_PW       = $clog2(WBQ_DEPTH) + 1;

    // Head/tail pointer: low bits index storage, MSB is the wrap flag.
    typedef logic [WBQ_PW-1:0] ptr_t;

    typedef struct packed {
        logic [WBQ_AW-1:0]    addr;
        logic [WBQ_WIDTH-1:0] data;
    } wbq_entry_t;

endpackage

// File: rtl/regfile_wb_queue_if.sv
// Bundle of the writeback-lane handshake, regfile write port and bypass read ports.
interface regfile_wb_queue_if
    import wbq_pkg::*;
#(
    parameter int unsigned WIDTH = WBQ_WIDTH,
    parameter int unsigned AW    = WBQ_AW,
    parameter int unsigned DEPTH = WBQ_DEPTH
);
    logic                                in0_valid;
    logic [AW-1:0]                       in0_addr;
    logic [WIDTH-1:0]                    in0_data;
    logic                                in1_valid;
    logic [AW-1:0]                       in1_addr;
    logic [WIDTH-1:0]                    in1_data;
    logic                                in_ready;
    logic                                wr_en;
    logic [AW-1:0]                       wr_addr;
    logic [WIDTH-1:0]                    wr_data;
    logic [WBQ_RD_PORTS-1:0][AW-1:0]     rd_addr;
    logic [WBQ_RD_PORTS-1:0]             rd_hit;
    logic [WBQ_RD_PORTS-1:0][WIDTH-1:0]  rd_data;
    logic [$clog2(DEPTH):0]              count;

    // Producer / regfile side
    modport master (
        output in0_valid, in0_addr, in0_data,
        output in1_valid, in1_addr, in1_data,
        output rd_addr,
        input  in_ready, wr_en, wr_addr, wr_data,
        input  rd_hit, rd_data, count
    );

    // Queue side
    modport slave (
        input  in0_valid, in0_addr, in0_data,
        input  in1_valid, in1_addr, in1_data,
        input  rd_addr,
        output in_ready, wr_en, wr_addr, wr_data,
        output rd_hit, rd_data, count
    );

endinterface

// File: rtl/regfile_wb_queue_match.sv
// Youngest-match search for one bypass read port. Entries arrive age-ordered,
// index 0 = oldest, so the last matching index scanned is the youngest.
module wbq_youngest_match #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 6,
    parameter int unsigned DEPTH = 8
) (
    input  logic [DEPTH-1:0][AW-1:0]    entry_addr,
    input  logic [DEPTH-1:0][WIDTH-1:0] entry_data,
    input  logic [DEPTH-1:0]            valid,
    input  logic [AW-1:0]               rd_addr,
    output logic                        hit,
    output logic [WIDTH-1:0]            data
);

    // Scan oldest to youngest; a younger match overrides an older one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (valid[k] && (entry_addr[k] == rd_addr)) begin
                hit  = 1'b1;
                data = entry_data[k];
            end
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback staging queue in front of the 6R/1W regfile RAM: takes up to two
// results per cycle, drains one per cycle in order, and offers a youngest-match
// bypass to the read ports. Bypass is built only when WBQ_BYPASS_EN is defined.
module regfile_wb_queue
    import wbq_pkg::*;
#(
    parameter int unsigned WIDTH = WBQ_WIDTH,
    parameter int unsigned AW    = WBQ_AW,
    parameter int unsigned DEPTH = WBQ_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    regfile_wb_queue_if.slave q
);

    localparam int unsigned LW = $clog2(DEPTH);
    localparam int unsigned PW = LW + 1;

    logic [AW-1:0]    mem_addr [DEPTH];
    logic [WIDTH-1:0] mem_data [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] count;
    logic [PW-1:0] n_enq;
    logic [LW-1:0] head_idx;
    logic [LW-1:0] tail_idx;
    logic [LW-1:0] tail1_idx;
    logic          in_ready;
    logic          wr_en;
    logic          take0;
    logic          take1;

    logic [WBQ_RD_PORTS-1:0]            rd_hit;
    logic [WBQ_RD_PORTS-1:0][WIDTH-1:0] rd_data;

    // Occupancy, handshake and enqueue decode from registered pointers only.
    always_comb begin
        count     = tail - head;
        head_idx  = head[LW-1:0];
        tail_idx  = tail[LW-1:0];
        tail1_idx = tail_idx + LW'(1);
        in_ready  = (count <= PW'(DEPTH - 2));
        wr_en     = (count != '0);
        take0     = in_ready & q.in0_valid;
        take1     = in_ready & q.in1_valid;
        n_enq     = PW'(take0) + PW'(take1);
    end

    // Pointer update: head follows every regfile write, tail every accepted lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else begin
            head <= head + PW'(wr_en);
            tail <= tail + n_enq;
        end
    end

    // Entry storage; lane 1 lands behind lane 0 when both fire.
    always_ff @(posedge clk) begin
        if (take0) begin
            mem_addr[tail_idx] <= q.in0_addr;
            mem_data[tail_idx] <= q.in0_data;
        end
        if (take1) begin
            mem_addr[take0 ? tail1_idx : tail_idx] <= q.in1_addr;
            mem_data[take0 ? tail1_idx : tail_idx] <= q.in1_data;
        end
    end

`ifdef WBQ_BYPASS_EN
    logic [DEPTH-1:0][AW-1:0]    age_addr;
    logic [DEPTH-1:0][WIDTH-1:0] age_data;
    logic [DEPTH-1:0]            age_valid;

    // Rotate storage into age order starting at head; only occupied slots are valid.
    always_comb begin
        logic [LW-1:0] idx;
        idx = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx          = head_idx + LW'(k);
            age_addr[k]  = mem_addr[idx];
            age_data[k]  = mem_data[idx];
            age_valid[k] = (PW'(k) < count);
        end
    end

    for (genvar i = 0; i < WBQ_RD_PORTS; i++) begin : g_match
        wbq_youngest_match #(
            .WIDTH (WIDTH),
            .AW    (AW),
            .DEPTH (DEPTH)
        ) u_match (
            .entry_addr (age_addr),
            .entry_data (age_data),
            .valid      (age_valid),
            .rd_addr    (q.rd_addr[i]),
            .hit        (rd_hit[i]),
            .data       (rd_data[i])
        );
    end
`else
    // No bypass: readers must wait for the queue to drain.
    always_comb begin
        rd_hit  = '0;
        rd_data = '0;
    end
`endif

    // Drive the bus; write port reads zero whenever nothing is pending.
    always_comb begin
        q.in_ready = in_ready;
        q.count    = count;
        q.wr_en    = wr_en;
        q.wr_addr  = wr_en ? mem_addr[head_idx] : '0;
        q.wr_data  = wr_en ? mem_data[head_idx] : '0;
        q.rd_hit   = rd_hit;
        q.rd_data  = rd_data;
    end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed self-checking bench for regfile_wb_queue (DEPTH=8).
module tb_regfile_wb_queue;
    import wbq_pkg::*;

`ifdef WBQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    wbq_entry_t obs[$];
    wbq_entry_t exp_q[$];

    regfile_wb_queue_if #(.WIDTH(32), .AW(6), .DEPTH(8)) bus ();

    regfile_wb_queue #(.WIDTH(32), .AW(6), .DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus)
    );

    always #5 clk = ~clk;

    // Record every regfile write; it commits at the following rising edge.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) obs.push_back({bus.wr_addr, bus.wr_data});
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (bus.count !== 4'd0 && n < 64) begin
            cyc();
            n++;
        end
        checks++;
        if (bus.count !== 4'd0) begin
            errors++;
            $display("FAIL %s_drain: count=%0d required 0", name, bus.count);
        end
    endtask

    task automatic test_reset();
        bus.in0_valid = 1'b0; bus.in0_addr = '0; bus.in0_data = '0;
        bus.in1_valid = 1'b0; bus.in1_addr = '0; bus.in1_data = '0;
        bus.rd_addr   = '0;
        rst = 1'b1;
        cyc();
        cyc();
        checks += 7;
        if (bus.count !== 4'd0)     begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        if (bus.wr_en !== 1'b0)     begin errors++; $display("FAIL reset_wr_en: got %b want 0", bus.wr_en); end
        if (bus.wr_addr !== 6'd0)   begin errors++; $display("FAIL reset_wr_addr: got %h want 0", bus.wr_addr); end
        if (bus.wr_data !== 32'd0)  begin errors++; $display("FAIL reset_wr_data: got %h want 0", bus.wr_data); end
        if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        if (bus.rd_hit !== 6'd0)    begin errors++; $display("FAIL reset_rd_hit: got %b want 0", bus.rd_hit); end
        if (bus.rd_data !== '0)     begin errors++; $display("FAIL reset_rd_data: got %h want 0", bus.rd_data); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_single();
        obs.delete();
        bus.in0_valid = 1'b1; bus.in0_addr = 6'd5; bus.in0_data = 32'hA5A5_0001;
        cyc();
        idle_inputs();
        checks += 4;
        if (bus.wr_en !== 1'b1)           begin errors++; $display("FAIL single_wr_en: got %b want 1", bus.wr_en); end
        if (bus.wr_addr !== 6'd5)         begin errors++; $display("FAIL single_wr_addr: got %0d want 5", bus.wr_addr); end
        if (bus.wr_data !== 32'hA5A5_0001) begin errors++; $display("FAIL single_wr_data: got %h want a5a50001", bus.wr_data); end
        if (bus.count !== 4'd1)           begin errors++; $display("FAIL single_count1: got %0d want 1", bus.count); end
        cyc();
        checks += 3;
        if (bus.wr_en !== 1'b0)  begin errors++; $display("FAIL single_idle_wr_en: got %b want 0", bus.wr_en); end
        if (bus.count !== 4'd0)  begin errors++; $display("FAIL single_count0: got %0d want 0", bus.count); end
        if (obs.size() != 1)     begin errors++; $display("FAIL single_nwrites: got %0d want 1", obs.size()); end
    endtask

    task automatic test_back_to_back();
        int  k = 0;
        int  n = 0;
        int  cnt = 0;
        int  peak = 0;
        bit  seen_low = 1'b0;
        bit  accept;
        obs.delete();
        exp_q.delete();
        for (int j = 0; j < 8; j++) begin
            exp_q.push_back({6'(j), 32'h1000_0000 + 32'(j)});
            exp_q.push_back({6'(j + 32), 32'h2000_0000 + 32'(j)});
        end
        while (k < 8 && n < 100) begin
            bus.in0_valid = 1'b1; bus.in0_addr = 6'(k);      bus.in0_data = 32'h1000_0000 + 32'(k);
            bus.in1_valid = 1'b1; bus.in1_addr = 6'(k + 32); bus.in1_data = 32'h2000_0000 + 32'(k);
            checks++;
            if (bus.in_ready !== (cnt <= 6)) begin
                errors++;
                $display("FAIL b2b_in_ready: got %b want %b at count %0d", bus.in_ready, (cnt <= 6), cnt);
            end
            accept = (cnt <= 6);
            if (bus.in_ready === 1'b0) seen_low = 1'b1;
            cyc();
            cnt = cnt + (accept ? 2 : 0) - ((cnt != 0) ? 1 : 0);
            if (cnt > peak) peak = cnt;
            checks++;
            if (bus.count !== 4'(cnt)) begin
                errors++;
                $display("FAIL b2b_count: got %0d want %0d", bus.count, cnt);
            end
            if (accept) k++;
            n++;
        end
        idle_inputs();
        checks += 3;
        if (k != 8)         begin errors++; $display("FAIL b2b_accept_timeout: got %0d pairs want 8", k); end
        if (!seen_low)      begin errors++; $display("FAIL b2b_backpressure: in_ready low seen=0 want 1"); end
        if (peak != 7)      begin errors++; $display("FAIL b2b_peak: got %0d want 7", peak); end
        wait_empty("b2b");
        checks++;
        if (obs.size() != 16) begin
            errors++;
            $display("FAIL b2b_nwrites: got %0d want 16", obs.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (obs[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL b2b_order[%0d]: got %h want %h", i, obs[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_same_addr();
        obs.delete();
        for (int p = 0; p < 5; p++) bus.rd_addr[p] = 6'd9;
        bus.rd_addr[5] = 6'h3F;
        checks++;
        if (bus.rd_hit !== 6'd0) begin errors++; $display("FAIL same_pre_hit: got %b want 0", bus.rd_hit); end
        bus.in0_valid = 1'b1; bus.in0_addr = 6'd9; bus.in0_data = 32'd1;
        bus.in1_valid = 1'b1; bus.in1_addr = 6'd9; bus.in1_data = 32'd2;
        cyc();
        idle_inputs();
        checks += 4;
        if (bus.rd_hit !== (BYP ? 6'b011111 : 6'd0))    begin errors++; $display("FAIL same_hit: got %b want %b", bus.rd_hit, (BYP ? 6'b011111 : 6'd0)); end
        if (bus.rd_data[0] !== (BYP ? 32'd2 : 32'd0))   begin errors++; $display("FAIL same_data0: got %h want %h", bus.rd_data[0], (BYP ? 32'd2 : 32'd0)); end
        if (bus.rd_data[4] !== (BYP ? 32'd2 : 32'd0))   begin errors++; $display("FAIL same_data4: got %h want %h", bus.rd_data[4], (BYP ? 32'd2 : 32'd0)); end
        if (bus.rd_data[5] !== 32'd0)                   begin errors++; $display("FAIL same_data5: got %h want 0", bus.rd_data[5]); end
        cyc();
        checks += 3;
        if (bus.count !== 4'd1)                         begin errors++; $display("FAIL same_count: got %0d want 1", bus.count); end
        if (bus.rd_hit[0] !== BYP)                      begin errors++; $display("FAIL same_head_hit: got %b want %b", bus.rd_hit[0], BYP); end
        if (bus.rd_data[0] !== (BYP ? 32'd2 : 32'd0))   begin errors++; $display("FAIL same_head_data: got %h want %h", bus.rd_data[0], (BYP ? 32'd2 : 32'd0)); end
        wait_empty("same");
        checks += 2;
        if (bus.rd_hit !== 6'd0) begin errors++; $display("FAIL same_post_hit: got %b want 0", bus.rd_hit); end
        if (obs.size() != 2 || obs[0] !== {6'd9, 32'd1} || obs[1] !== {6'd9, 32'd2}) begin
            errors++;
            $display("FAIL same_writes: got %0d writes first %h want (9,1),(9,2)", obs.size(), (obs.size() > 0) ? obs[0] : '0);
        end
        bus.rd_addr = '0;
    endtask

    task automatic test_reset_mid_drain();
        for (int j = 0; j < 5; j++) begin
            bus.in0_valid = 1'b1; bus.in0_addr = 6'(16 + 2 * j); bus.in0_data = 32'h3000_0000 + 32'(2 * j);
            bus.in1_valid = 1'b1; bus.in1_addr = 6'(17 + 2 * j); bus.in1_data = 32'h3000_0001 + 32'(2 * j);
            cyc();
        end
        idle_inputs();
        checks += 2;
        if (bus.count !== 4'd6) begin errors++; $display("FAIL rstmid_fill: got %0d want 6", bus.count); end
        if (bus.wr_en !== 1'b1) begin errors++; $display("FAIL rstmid_draining: got %b want 1", bus.wr_en); end
        #2;
        rst = 1'b1;
        #1;
        checks += 4;
        if (bus.wr_en !== 1'b0)    begin errors++; $display("FAIL rstmid_wr_en: got %b want 0", bus.wr_en); end
        if (bus.count !== 4'd0)    begin errors++; $display("FAIL rstmid_count: got %0d want 0", bus.count); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b want 1", bus.in_ready); end
        if (bus.wr_data !== 32'd0) begin errors++; $display("FAIL rstmid_wr_data: got %h want 0", bus.wr_data); end
        cyc();
        cyc();
        rst = 1'b0;
        obs.delete();
        bus.in1_valid = 1'b1; bus.in1_addr = 6'd7; bus.in1_data = 32'h0000_0077;
        cyc();
        idle_inputs();
        checks += 3;
        if (bus.wr_en !== 1'b1)          begin errors++; $display("FAIL rstmid_post_wr_en: got %b want 1", bus.wr_en); end
        if (bus.wr_addr !== 6'd7)        begin errors++; $display("FAIL rstmid_post_addr: got %0d want 7", bus.wr_addr); end
        if (bus.wr_data !== 32'h77)      begin errors++; $display("FAIL rstmid_post_data: got %h want 77", bus.wr_data); end
        cyc();
        checks += 2;
        if (bus.count !== 4'd0) begin errors++; $display("FAIL rstmid_post_count: got %0d want 0", bus.count); end
        if (obs.size() != 1)    begin errors++; $display("FAIL rstmid_nwrites: got %0d want 1", obs.size()); end
    endtask

    task automatic test_wrap();
        obs.delete();
        exp_q.delete();
        for (int j = 0; j < 20; j++) begin
            if (j % 2 == 0) begin
                bus.in0_valid = 1'b1; bus.in1_valid = 1'b0;
                bus.in0_addr = 6'((j * 3) % 64); bus.in0_data = 32'h5000_0000 + 32'(j);
            end else begin
                bus.in0_valid = 1'b0; bus.in1_valid = 1'b1;
                bus.in1_addr = 6'((j * 3) % 64); bus.in1_data = 32'h5000_0000 + 32'(j);
            end
            exp_q.push_back({6'((j * 3) % 64), 32'h5000_0000 + 32'(j)});
            cyc();
            checks++;
            if (bus.count !== 4'd1) begin
                errors++;
                $display("FAIL wrap_count[%0d]: got %0d want 1", j, bus.count);
            end
        end
        idle_inputs();
        wait_empty("wrap");
        checks++;
        if (obs.size() != 20) begin
            errors++;
            $display("FAIL wrap_nwrites: got %0d want 20", obs.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                checks++;
                if (obs[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL wrap_order[%0d]: got %h want %h", i, obs[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_same_addr();
        test_reset_mid_drain();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
